// File: rtl/axi_enum_packet.sv
// Shared FSM state enums, response codes and the burst legality check for axi4_slave_mem.
// Define AXI_BOUNDARY_CHECK_EN to also reject bursts that cross a 4KB page.
package axi_enum_packet;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index is always addr>>2, independent of SIZE; the bus is 32-bit words.
    function automatic logic burst_err(input logic [31:0] addr,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size,
                                       input int unsigned depth);
        logic [31:0] nbeats;
        logic        err;
        nbeats = {24'd0, len} + 32'd1;
        err    = (size > 3'd2) || (((addr >> 2) + nbeats) > 32'(depth));
`ifdef AXI_BOUNDARY_CHECK_EN
        err    = err || (({20'd0, addr[11:0]} + (nbeats << size)) > 32'd4096);
`endif
        return err;
    endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Word-wide storage for axi4_slave_mem: one synchronous write port, one registered
// read port with read-before-write behaviour on a same-address collision.
module axi4_mem_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024,
    localparam int IDX_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [IDX_W-1:0]      rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // No reset: contents must survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 INCR-burst memory slave with independent write and read FSMs over axi4_mem_array.
// Bursts that are oversize or out of range (and, with AXI_BOUNDARY_CHECK_EN, cross 4KB) get SLVERR.
module axi4_slave_mem
    import axi_enum_packet::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    input  logic                  WLAST,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    output logic                  RLAST,
    input  logic                  RREADY
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    wstate_e                wstate_q;
    logic [IDX_W-1:0]       awword_q;
    logic [7:0]             awlen_q;
    logic [7:0]             wbeat_q;
    logic                   werr_q;
    logic                   wlast_err_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;

    rstate_e                rstate_q;
    logic [IDX_W-1:0]       arword_q;
    logic [7:0]             arlen_q;
    logic [7:0]             rbeat_q;
    logic                   rerr_q;
    logic                   rvalid_q;
    logic                   rlast_q;
    logic [1:0]             rresp_q;

    logic                   aw_err_d;
    logic                   ar_err_d;
    logic                   wr_en_d;
    logic [IDX_W-1:0]       wr_addr_d;
    logic                   rd_en_d;
    logic [IDX_W-1:0]       rd_addr_d;
    logic [DATA_WIDTH-1:0]  mem_rd_data;

    always_comb begin
        aw_err_d  = burst_err(32'(AWADDR), AWLEN, AWSIZE, MEMORY_DEPTH);
        ar_err_d  = burst_err(32'(ARADDR), ARLEN, ARSIZE, MEMORY_DEPTH);
        wr_en_d   = (wstate_q == W_DATA) && WVALID && !werr_q;
        wr_addr_d = awword_q + IDX_W'(wbeat_q);
        // Fetch beat 0 on the AR handshake, then prefetch the next beat on each R handshake.
        rd_en_d   = ((rstate_q == R_IDLE) && ARVALID && !ar_err_d) ||
                    ((rstate_q == R_DATA) && RREADY && (rbeat_q != arlen_q) && !rerr_q);
        rd_addr_d = (rstate_q == R_IDLE) ? ARADDR[IDX_W+1:2]
                                         : arword_q + IDX_W'(rbeat_q + 8'd1);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q    <= W_IDLE;
            awword_q    <= '0;
            awlen_q     <= '0;
            wbeat_q     <= '0;
            werr_q      <= 1'b0;
            wlast_err_q <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: if (AWVALID) begin
                    awword_q    <= AWADDR[IDX_W+1:2];
                    awlen_q     <= AWLEN;
                    werr_q      <= aw_err_d;
                    wbeat_q     <= '0;
                    wlast_err_q <= 1'b0;
                    wstate_q    <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    if (wbeat_q == awlen_q) begin
                        wstate_q <= W_RESP;
                        wbeat_q  <= '0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (werr_q || wlast_err_q || !WLAST) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wbeat_q <= wbeat_q + 8'd1;
                        if (WLAST) begin
                            wlast_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: if (BREADY) begin
                    bvalid_q <= 1'b0;
                    wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q <= R_IDLE;
            arword_q <= '0;
            arlen_q  <= '0;
            rbeat_q  <= '0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: if (ARVALID) begin
                    arword_q <= ARADDR[IDX_W+1:2];
                    arlen_q  <= ARLEN;
                    rerr_q   <= ar_err_d;
                    rbeat_q  <= '0;
                    rvalid_q <= 1'b1;
                    rlast_q  <= (ARLEN == 8'd0);
                    rresp_q  <= ar_err_d ? RESP_SLVERR : RESP_OKAY;
                    rstate_q <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (rbeat_q == arlen_q) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rresp_q  <= RESP_OKAY;
                        rbeat_q  <= '0;
                    end else begin
                        rbeat_q <= rbeat_q + 8'd1;
                        rlast_q <= ((rbeat_q + 8'd1) == arlen_q);
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    axi4_mem_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH)
    ) u_mem (
        .clk_i     (ACLK),
        .wr_en_i   (wr_en_d),
        .wr_addr_i (wr_addr_d),
        .wr_data_i (WDATA),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (mem_rd_data)
    );

    assign AWREADY = (wstate_q == W_IDLE);
    assign WREADY  = (wstate_q == W_DATA);
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = (rstate_q == R_IDLE);
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    // Error bursts and idle cycles present zero data.
    assign RDATA   = (rvalid_q && !rerr_q) ? mem_rd_data : '0;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem; expectations follow AXI_BOUNDARY_CHECK_EN when defined.
module tb_axi4_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];
    logic [1:0]  bresp_got;
    bit          bnd;

    always #5 ACLK = ~ACLK;

    axi4_slave_mem #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (16),
        .MEMORY_DEPTH (2048)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [31:0] base, input bit err);
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = err ? 32'd0 : base + 32'(i);
            exp_resp[i] = err ? 2'b10 : 2'b00;
        end
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [31:0] base, input int bad_last, input int take,
                             output logic [1:0] resp);
        int n;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        chk("awready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < take; i++) begin
            WDATA  = base + 32'(i);
            WLAST  = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 20) begin @(posedge ACLK); #1; n++; end
            chk("wready", 32'(WREADY), 32'd1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        resp = 2'bxx;
        if (take == int'(len) + 1) begin
            chk("bvalid_latency", 32'(BVALID), 32'd1);
            resp   = BRESP;
            BREADY = 1'b1;
            @(posedge ACLK); #1;
            BREADY = 1'b0;
            chk("bvalid_clear", 32'(BVALID), 32'd0);
        end
        $display("write addr=%h len=%0d size=%0d beats=%0d bresp=%b", addr, len, size, take, resp);
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int take, input int stall_beat, input int stall_n);
        int n;
        ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        chk("arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        chk("rvalid_latency", 32'(RVALID), 32'd1);
        for (int i = 0; i < take; i++) begin
            if (i == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge ACLK); #1;
                    chk("stall_rvalid", 32'(RVALID), 32'd1);
                    chk("stall_rdata", RDATA, exp_data[i]);
                    chk("stall_rresp", 32'(RRESP), 32'(exp_resp[i]));
                    chk("stall_rlast", 32'(RLAST), 32'(i == int'(len)));
                end
            end
            n = 0;
            while (!RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
            chk("rvalid", 32'(RVALID), 32'd1);
            chk("rdata", RDATA, exp_data[i]);
            chk("rresp", 32'(RRESP), 32'(exp_resp[i]));
            chk("rlast", 32'(RLAST), 32'(i == int'(len)));
            RREADY = 1'b1;
            @(posedge ACLK); #1;
            RREADY = 1'b0;
        end
        if (take == int'(len) + 1) begin
            chk("rvalid_end", 32'(RVALID), 32'd0);
            chk("arready_end", 32'(ARREADY), 32'd1);
        end
        $display("read  addr=%h len=%0d size=%0d beats=%0d first=%h", addr, len, size, take, exp_data[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AXI_BOUNDARY_CHECK_EN
        bnd = 1'b1;
`else
        bnd = 1'b0;
`endif
        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
        WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
        #23;
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Basic 4-beat write then readback.
        axi_write(16'h0010, 8'd3, 3'd2, 32'hA0, -1, 4, bresp_got);
        chk("bresp_basic", 32'(bresp_got), 32'(2'b00));
        set_exp(32'hA0, 1'b0);
        axi_read(16'h0010, 8'd3, 3'd2, 4, -1, 0);

        // 4KB crossing at 0x0FFC: in range for a 2048-word memory, error only with the macro.
        axi_write(16'h0FFC, 8'd1, 3'd2, 32'hB0, -1, 2, bresp_got);
        chk("bresp_4k", 32'(bresp_got), bnd ? 32'(2'b10) : 32'(2'b00));
        set_exp(32'hB0, bnd);
        axi_read(16'h0FFC, 8'd1, 3'd2, 2, -1, 0);

        // Burst ending exactly on the last word is legal; one word further is not.
        axi_write(16'h1FF0, 8'd3, 3'd2, 32'hC0, -1, 4, bresp_got);
        chk("bresp_fit", 32'(bresp_got), 32'(2'b00));
        axi_write(16'h1FFC, 8'd3, 3'd2, 32'hD0, -1, 4, bresp_got);
        chk("bresp_range", 32'(bresp_got), 32'(2'b10));
        set_exp(32'hC0, 1'b0);
        axi_read(16'h1FF0, 8'd3, 3'd2, 4, -1, 0);

        axi_write(16'h0100, 8'd0, 3'd3, 32'hF0, -1, 1, bresp_got);
        chk("bresp_size", 32'(bresp_got), 32'(2'b10));

        // Back-pressure: RREADY low for 5 cycles before beat 2.
        set_exp(32'hA0, 1'b0);
        axi_read(16'h0010, 8'd3, 3'd2, 4, 2, 5);

        // Error read still produces LEN+1 zero beats.
        set_exp(32'h0, 1'b1);
        axi_read(16'h0010, 8'd2, 3'd3, 3, -1, 0);

        axi_write(16'h0040, 8'd3, 3'd2, 32'h50, 1, 4, bresp_got);
        chk("bresp_wlast", 32'(bresp_got), 32'(2'b10));

        // Reset mid-write: first two beats persist.
        axi_write(16'h0080, 8'd3, 3'd2, 32'hE0, -1, 2, bresp_got);
        ARESETn = 1'b0;
        #1;
        chk("wrst_wready", 32'(WREADY), 32'd0);
        chk("wrst_awready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        set_exp(32'hE0, 1'b0);
        axi_read(16'h0080, 8'd1, 3'd2, 2, -1, 0);

        // Reset mid-read, then the memory still holds the first burst.
        set_exp(32'hA0, 1'b0);
        axi_read(16'h0010, 8'd3, 3'd2, 1, -1, 0);
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        chk("rrst_rvalid", 32'(RVALID), 32'd0);
        chk("rrst_arready", 32'(ARREADY), 32'd1);
        chk("rrst_rdata", RDATA, 32'd0);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        axi_read(16'h0010, 8'd3, 3'd2, 4, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 1024, number of DATA_WIDTH words.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as the ports ACLK and ARESETn below.
REQ-005 SHALL have these ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- AWADDR  in  ADDR_WIDTH  write start byte address
- AWLEN  in  8  beats minus 1
- AWSIZE  in  3  log2 bytes per beat
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WVALID  in  1  write data valid
- WLAST  in  1  last write beat
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- ARADDR  in  ADDR_WIDTH  read start byte address
- ARLEN  in  8  beats minus 1
- ARSIZE  in  3  log2 bytes per beat
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RLAST  out  1  last read beat
- RREADY  in  1  read data ready

Function
REQ-006 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); INCR bursts only.
REQ-007 AWREADY SHALL be 1 only in W_IDLE; AWVALID&AWREADY latches AWADDR/AWLEN/AWSIZE, computes error flag, and moves to W_DATA.
REQ-008 Error flag SHALL be set when SIZE>2, or (addr>>2)+LEN+1 > MEMORY_DEPTH, or (addr mod 4096)+(LEN+1)<<SIZE > 4096.
REQ-009 WREADY SHALL be 1 only in W_DATA; each WVALID&WREADY writes WDATA to word (AWADDR>>2)+beat unless the error flag is set, and increments the beat counter.
REQ-010 W_DATA SHALL exit to W_RESP on the handshake at beat==AWLEN; WLAST asserted on any other beat, or deasserted on that beat, SHALL force BRESP=2'b10.
REQ-011 W_RESP SHALL hold BVALID=1, BRESP=2'b00 (OKAY) or 2'b10 (SLVERR) stable until BREADY; then return to W_IDLE.
REQ-012 ARREADY SHALL be 1 only in R_IDLE; AR handshake latches fields, computes error per REQ-008, registers beat 0 into RDATA, and enters R_DATA.
REQ-013 R_DATA SHALL hold RVALID=1; RDATA/RRESP/RLAST SHALL stay stable until RVALID&RREADY, which loads the next beat; RLAST=1 only at beat==ARLEN.
REQ-014 An error read SHALL return RDATA=0 and RRESP=2'b10 on every beat, with LEN+1 beats still produced.
REQ-015 On the final R handshake, the FSM SHALL return to R_IDLE, and RVALID SHALL be 0 the next cycle.
REQ-016 A same-cycle write and read load of the same word SHALL return the old value to RDATA.
REQ-017 Address latency SHALL be 1 cycle from AR handshake to first RVALID, and 1 cycle from the last W handshake to BVALID.

Reset
REQ-018 While ARESETn=0, SHALL force both FSMs to idle; AWREADY=ARREADY=1; WREADY=BVALID=RVALID=RLAST=0; BRESP=RRESP=0; RDATA=0; beat counters=0.
REQ-019 Reset mid-burst SHALL abandon the burst; words already written SHALL persist; memory contents SHALL NOT be cleared.

Configuration
REQ-020 With AXI_BOUNDARY_CHECK_EN defined, the 4KB-crossing term of REQ-008 SHALL apply.
REQ-021 With AXI_BOUNDARY_CHECK_EN undefined, 4KB crossings SHALL be OKAY, and only the SIZE and range terms SHALL apply.

Structure
REQ-022 Package axi_enum_packet SHALL hold the write-state and read-state enums and the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
REQ-023 Storage SHALL be in sub-module axi4_mem_array: 1 sync write port and 1 read port, MEMORY_DEPTH x DATA_WIDTH.

Verification
REQ-024 AW 0x0010 LEN=3 SIZE=2, WDATA A0..A3 -> BRESP=00; a read of the same range returns A0..A3 with RLAST on beat 3.
REQ-025 AR 0x0FFC LEN=1 SIZE=2 with the macro on -> two beats RDATA=0, RRESP=10; with the macro off -> OKAY.
REQ-026 AW 0x0FFC LEN=3 (word 1023+4>1024) -> BRESP=10; memory words are unchanged on readback.
REQ-027 RREADY held 0 for 5 cycles mid-burst -> RDATA, RRESP and RLAST stay stable, and no beat is lost.
REQ-028 WLAST=1 on beat 1 of LEN=3 -> BRESP=10; ARESETn pulsed mid-read -> RVALID=0 and ARREADY=1 the next cycle.
